// File: rtl/fir_coef_loader_if.sv
// Coefficient-set handshake between the coefficient source and the loader.
// A set transfers on any rising edge where coef_valid and coef_ready are both high.
interface fir_coef_loader_if #(
    parameter int TOT = 32
);
    logic           coef_valid;
    logic [TOT-1:0] coef_data;
    logic           coef_ready;

    modport master (output coef_valid, output coef_data, input coef_ready);
    modport slave  (input coef_valid, input coef_data, output coef_ready);
endinterface

// File: rtl/fir_coef_loader.sv
// Loads a parallel coefficient set and serializes it MSB-first onto the FIR
// coefficient shift chain, one bit per shiftEn cycle, then pulses done.
module fir_coef_loader #(
    parameter  int NTAPS = 4,
    parameter  int CW    = 8,
    localparam int TOT   = NTAPS * CW,
    localparam int CNTW  = $clog2(TOT + 1)
) (
    input  logic              ph1,
    input  logic              reset,
    fir_coef_loader_if.slave  cif,
    input  logic              abort,
    output logic              shiftIn,
    output logic              shiftEn,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [TOT-1:0]  sreg_q;
    logic [TOT-1:0]  sreg_d;
    logic [CNTW-1:0] cnt_q;
    logic            ready_q;
    logic            shift_in_q;
    logic            shift_en_q;
    logic            busy_q;
    logic            done_q;

    assign sreg_d         = {sreg_q[TOT-2:0], 1'b0};
    assign cif.coef_ready = ready_q;
    assign shiftIn        = shift_in_q;
    assign shiftEn        = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign state_dbg      = state_q;

    // shiftIn is a flop loaded with the bit for the coming cycle, so it is
    // stable for the whole cycle the filter shifts on.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sreg_q     <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            shift_in_q <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (cif.coef_valid && ready_q) begin
                        state_q    <= S_SHIFT;
                        sreg_q     <= cif.coef_data;
                        cnt_q      <= CNTW'(TOT);
                        ready_q    <= 1'b0;
                        shift_in_q <= cif.coef_data[TOT-1];
                        shift_en_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        sreg_q     <= '0;
                        cnt_q      <= '0;
                        ready_q    <= 1'b1;
                        shift_in_q <= 1'b0;
                        shift_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        sreg_q <= sreg_d;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == CNTW'(1)) begin
                            state_q    <= S_DONE;
                            shift_in_q <= 1'b0;
                            shift_en_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            shift_in_q <= sreg_q[TOT-2];
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= S_IDLE;
                    ready_q    <= 1'b0;
                    shift_en_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: directed load/abort/reset scenarios plus random
// traffic, checked against a cycle-timeline model of a load and a word scoreboard.
module tb_fir_coef_loader;

    localparam int TOT = 32;

    logic ph1;
    logic reset;
    logic abort;
    logic shiftIn, shiftEn, busy, done;
    logic [1:0] state_dbg;

    fir_coef_loader_if #(.TOT(TOT)) cif ();

    fir_coef_loader dut (
        .ph1       (ph1),
        .reset     (reset),
        .cif       (cif.slave),
        .abort     (abort),
        .shiftIn   (shiftIn),
        .shiftEn   (shiftEn),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: k = cycles since the accepting edge (0 = no load in flight).
    // A load shows shiftEn on cycles 1..TOT carrying bit TOT-k, done on TOT+1.
    logic [TOT-1:0] exp_q[$];
    logic [TOT-1:0] cur_word;
    logic [TOT-1:0] cap;
    logic [TOT-1:0] chain;
    int k = 0;
    int nshift = 0;
    int n_done = 0;
    int cyc = 0;
    int last_hs = 0;
    int gap = 0;
    bit fresh = 1'b1;
    bit exp_ready, exp_en;

    always @(negedge ph1) begin
        cyc++;
        if (!reset) begin
            check_val("reset_outs", {cif.coef_ready, shiftEn, shiftIn, busy, done}, 32'd0);
            k = 0;
            fresh = 1'b1;
            exp_q.delete();
            nshift = 0;
            cap = '0;
        end else begin
            exp_ready = (k == 0) && !fresh;
            exp_en    = (k >= 1) && (k <= TOT);
            check_val("ctrl{rdy,en,busy,done}", {cif.coef_ready, shiftEn, busy, done},
                      {28'd0, exp_ready, exp_en, exp_en, (k == TOT + 1)});
            if (exp_en) check_val("shiftIn", shiftIn, cur_word[TOT-k]);
            if (shiftEn) begin
                cap   = {cap[TOT-2:0], shiftIn};
                chain = {chain[TOT-2:0], shiftIn};
                nshift++;
            end
            if (done) n_done++;
            fresh = 1'b0;
            if (k == TOT + 1) begin
                check_val("shift_count", nshift, TOT);
                if (exp_q.size() > 0) check_val("stream", cap, exp_q.pop_front());
                nshift = 0;
                k = 0;
            end else if (k == 0) begin
                if (exp_ready && cif.coef_valid) begin
                    k = 1;
                    cur_word = cif.coef_data;
                    exp_q.push_back(cif.coef_data);
                    gap = cyc - last_hs;
                    last_hs = cyc;
                    cap = '0;
                    nshift = 0;
                end
            end else if (abort) begin
                k = 0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                nshift = 0;
            end else begin
                k++;
            end
        end
    end

    task automatic load(input logic [TOT-1:0] d);
        int t;
        t = 0;
        @(posedge ph1); #1;
        cif.coef_valid = 1'b1;
        cif.coef_data  = d;
        forever begin
            @(negedge ph1);
            if (cif.coef_ready) break;
            t++;
            if (t > 200) begin
                check_val("load_timeout", cif.coef_ready, 1);
                break;
            end
        end
        @(posedge ph1); #1;
        cif.coef_valid = 1'b0;
        cif.coef_data  = $urandom();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        forever begin
            @(negedge ph1);
            if (done) break;
            t++;
            if (t > 200) begin
                check_val("done_timeout", done, 1);
                break;
            end
        end
    endtask

    task automatic check_chain(input logic [31:0] w);
        check_val("chain_c0", chain[7:0], w[7:0]);
        check_val("chain_c1", chain[15:8], w[15:8]);
        check_val("chain_c2", chain[23:16], w[23:16]);
        check_val("chain_c3", chain[31:24], w[31:24]);
    endtask

    int base;

    initial begin
        reset = 1'b0;
        abort = 1'b0;
        cif.coef_valid = 1'b0;
        cif.coef_data  = '0;
        chain = '0;

        // reset held 3 cycles, then ready appears one edge after release
        repeat (3) @(posedge ph1);
        #1 check_val("reset_ready", cif.coef_ready, 0);
        reset = 1'b1;
        @(negedge ph1);
        check_val("ready_before_edge", cif.coef_ready, 0);
        @(negedge ph1);
        check_val("ready_after_edge", cif.coef_ready, 1);

        // basic load: c3..c0 = 1,2,3,4
        load(32'h01020304);
        wait_done();
        check_chain(32'h01020304);

        // valid held through SHIFT with other data: accepted right when ready returns
        @(posedge ph1); #1;
        cif.coef_valid = 1'b1;
        cif.coef_data  = 32'hDEADBEEF;
        @(negedge ph1);
        while (!cif.coef_ready) @(negedge ph1);
        @(posedge ph1); #1;
        cif.coef_data = 32'h13572468;
        wait_done();
        @(negedge ph1);
        check_val("ready_after_done", cif.coef_ready, 1);
        @(posedge ph1); #1;
        cif.coef_valid = 1'b0;
        wait_done();
        check_val("b2b_gap", gap, TOT + 2);
        check_chain(32'h13572468);

        // abort during the 10th shift cycle
        load(32'hCAFE1234);
        repeat (9) @(posedge ph1);
        #1 abort = 1'b1;
        @(posedge ph1); #1;
        abort = 1'b0;
        check_val("abort_shiften", shiftEn, 0);
        check_val("abort_ready", cif.coef_ready, 1);
        repeat (3) begin
            @(negedge ph1);
            check_val("abort_no_done", done, 0);
        end

        // asynchronous reset in the middle of a load
        load(32'hA5A55A5A);
        repeat (19) @(posedge ph1);
        #1 check_val("pre_reset_shiften", shiftEn, 1);
        #1 reset = 1'b0;
        #1 check_val("async_shiften", shiftEn, 0);
        check_val("async_busy", busy, 0);
        @(posedge ph1); #1;
        reset = 1'b1;
        load(32'hFF807F00);
        wait_done();
        check_chain(32'hFF807F00);

        // random traffic: valid/data jitter every cycle, rare aborts
        base = n_done;
        for (int c = 0; c < 20000 && (n_done - base) < 100; c++) begin
            @(posedge ph1); #1;
            cif.coef_valid = ($urandom_range(0, 3) != 0);
            cif.coef_data  = $urandom();
            abort = ($urandom_range(0, 199) == 0);
        end
        check_val("random_loads", n_done - base, 100);
        @(posedge ph1); #1;
        cif.coef_valid = 1'b0;
        abort = 1'b0;
        repeat (40) @(posedge ph1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
